multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memories (slave).
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_taken;
    logic        imem_valid;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_b_imm;
    logic        dmem_re;
    logic        dmem_we;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, br_taken, imem_valid, dmem_ready,
        output imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               alu_b_imm, dmem_re, dmem_we, illegal, state, instret
    );

    modport slave (
        output opcode, funct3, br_taken, imem_valid, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               alu_b_imm, dmem_re, dmem_we, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB/TRAP controller for a multicycle RV32I-style core.
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master ctrl
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL
    } cls_e;

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d, dec_cls;
    logic       imem_req_q, alu_b_imm_q, dmem_re_q, dmem_we_q, rf_we_q, illegal_q;
    logic [1:0] wb_sel_q, wb_pc_sel_q;
    logic       br_retire, st_retire, pc_we;

    always_comb begin
        dec_cls = C_ILL;
        case (ctrl.opcode)
            7'b0110011: dec_cls = C_OP;
            7'b0010011: dec_cls = C_OPIMM;
            7'b0000011: dec_cls = (ctrl.funct3 == 3'b011 || ctrl.funct3[2:1] == 2'b11) ? C_ILL : C_LOAD;
            7'b0100011: dec_cls = (ctrl.funct3[2] || ctrl.funct3 == 3'b011) ? C_ILL : C_STORE;
            7'b1100011: dec_cls = (ctrl.funct3[2:1] == 2'b01) ? C_ILL : C_BRANCH;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            default:    dec_cls = C_ILL;
        endcase
    end

    // The instruction class is captured in DECODE so later states need not trust the bus.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_FETCH:  if (ctrl.imem_valid) state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_FETCH;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM:    if (ctrl.dmem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // State-only outputs are registered from the next state; FETCH requests right out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            cls_q       <= C_OP;
            imem_req_q  <= 1'b1;
            alu_b_imm_q <= 1'b0;
            dmem_re_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            wb_sel_q    <= 2'd0;
            wb_pc_sel_q <= 2'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            imem_req_q  <= (state_d == S_FETCH);
            alu_b_imm_q <= (state_d == S_EXEC) && (cls_d != C_OP) && (cls_d != C_BRANCH);
            dmem_re_q   <= (state_d == S_MEM) && (cls_d == C_LOAD);
            dmem_we_q   <= (state_d == S_MEM) && (cls_d == C_STORE);
            rf_we_q     <= (state_d == S_WB);
            wb_sel_q    <= (state_d != S_WB) ? 2'd0 :
                           (cls_d == C_LOAD) ? 2'd1 :
                           (cls_d == C_JAL || cls_d == C_JALR) ? 2'd2 : 2'd0;
            wb_pc_sel_q <= (state_d != S_WB) ? 2'd0 :
                           (cls_d == C_JAL)  ? 2'd1 :
                           (cls_d == C_JALR) ? 2'd2 : 2'd0;
            illegal_q   <= (state_d == S_TRAP);
        end
    end

    // Retire strobes that depend on same-cycle inputs (fetch valid, branch result, memory ready).
    assign br_retire = (state_q == S_EXEC) && (cls_q == C_BRANCH);
    assign st_retire = (state_q == S_MEM) && (cls_q == C_STORE) && ctrl.dmem_ready;
    assign pc_we     = rf_we_q | br_retire | st_retire;

    assign ctrl.imem_req  = imem_req_q;
    assign ctrl.ir_we     = (state_q == S_FETCH) && ctrl.imem_valid;
    assign ctrl.pc_we     = pc_we;
    assign ctrl.pc_sel    = wb_pc_sel_q | ((br_retire && ctrl.br_taken) ? 2'd1 : 2'd0);
    assign ctrl.rf_we     = rf_we_q;
    assign ctrl.wb_sel    = wb_sel_q;
    assign ctrl.alu_b_imm = alu_b_imm_q;
    assign ctrl.dmem_re   = dmem_re_q;
    assign ctrl.dmem_we   = dmem_we_q;
    assign ctrl.illegal   = illegal_q;
    assign ctrl.state     = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign ctrl.instret = instret_q;
`else
    assign ctrl.instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction cycle-trace reference model.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_R   = 7'b0110011, OP_I    = 7'b0010011, OP_LD  = 7'b0000011,
                           OP_ST  = 7'b0100011, OP_BR   = 7'b1100011, OP_LUI = 7'b0110111,
                           OP_AUI = 7'b0010111, OP_JAL  = 7'b1101111, OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_we, pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_b_imm, dmem_re, dmem_we, illegal;
    } out_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       iv, dr, bt;
        out_t       want;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .ctrl(bus));

    cyc_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret  = '0;
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic [6:0]  legal_ops[9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_R, OP_I, OP_LUI, OP_AUI, OP_JAL, OP_JALR: return 1'b1;
            OP_BR:   return !(f3 == 3'd2 || f3 == 3'd3);
            OP_LD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            OP_ST:   return f3 inside {3'd0, 3'd1, 3'd2};
            default: return 1'b0;
        endcase
    endfunction

    function automatic out_t observe();
        out_t o;
        o.st = bus.state;         o.imem_req = bus.imem_req; o.ir_we = bus.ir_we;
        o.pc_we = bus.pc_we;      o.pc_sel = bus.pc_sel;     o.rf_we = bus.rf_we;
        o.wb_sel = bus.wb_sel;    o.alu_b_imm = bus.alu_b_imm;
        o.dmem_re = bus.dmem_re;  o.dmem_we = bus.dmem_we;   o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic push(input logic iv, input logic dr, input logic bt, input out_t e);
        cyc_t c;
        c.op = cur_op; c.f3 = cur_f3; c.iv = iv; c.dr = dr; c.bt = bt; c.want = e;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, built from the phase rules.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3,
                               input int fw, input int mw, input logic bt);
        out_t e;
        bit   ld = (op == OP_LD), st = (op == OP_ST);
        cur_op = op; cur_f3 = f3;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.imem_req = 1'b1; push(1'b0, rb(), rb(), e);
        end
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; push(1'b1, rb(), rb(), e);
        e = '0; e.st = 3'd1; push(rb(), rb(), rb(), e);
        if (!is_legal(op, f3)) begin
            for (int i = 0; i < 20; i++) begin
                e = '0; e.st = 3'd5; e.illegal = 1'b1; push(rb(), rb(), rb(), e);
            end
            return;
        end
        e = '0; e.st = 3'd2; e.alu_b_imm = !(op == OP_R || op == OP_BR);
        if (op == OP_BR) begin
            e.pc_we = 1'b1; e.pc_sel = bt ? 2'd1 : 2'd0;
            push(rb(), rb(), bt, e);
            return;
        end
        push(rb(), rb(), rb(), e);
        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.st = 3'd3; e.dmem_re = ld; e.dmem_we = st;
                e.pc_we = st && (i == mw);
                push(rb(), (i == mw), rb(), e);
            end
            if (st) return;
        end
        e = '0; e.st = 3'd4; e.rf_we = 1'b1; e.pc_we = 1'b1;
        e.pc_sel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
        e.wb_sel = ld ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
        push(rb(), rb(), rb(), e);
    endtask

    // Called just after a rising edge; consumes up to n trace cycles.
    task automatic run(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            bus.opcode = c.op; bus.funct3 = c.f3;
            bus.imem_valid = c.iv; bus.dmem_ready = c.dr; bus.br_taken = c.bt;
            @(negedge clk);
            check($sformatf("op%b_st%0d", c.op, c.want.st), 32'(observe()), 32'(c.want));
            check("instret", bus.instret, exp_ret);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
            if (c.want.pc_we) exp_ret = exp_ret + 32'd1;
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int fw, input int mw, input logic bt);
        int n;
        int e0 = n_errors;
        model_instr(op, f3, fw, mw, bt);
        n = q.size();
        run(n);
        $display("instr op=%b f3=%0d fwait=%0d mwait=%0d bt=%0b cycles=%0d errors=%0d",
                 op, f3, fw, mw, bt, n, n_errors - e0);
    endtask

    task automatic do_reset(input string tag);
        out_t e;
        rst = 1'b1; bus.imem_valid = 1'b0; bus.dmem_ready = 1'b0; bus.br_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; exp_ret = '0;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        check(tag, 32'(observe()), 32'(e));
        check({tag, "_instret"}, bus.instret, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle_check_instret(input string tag, input logic [31:0] want);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        check(tag, bus.instret, want);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        bus.opcode = OP_I; bus.funct3 = 3'd0;
        bus.imem_valid = 1'b0; bus.dmem_ready = 1'b0; bus.br_taken = 1'b0;
        do_reset("reset_init");

        do_instr(OP_I,  3'd0, 0, 0, 1'b0);
        do_instr(OP_LD, 3'd2, 0, 3, 1'b0);
        do_instr(OP_BR, 3'd0, 1, 0, 1'b1);
        do_instr(OP_BR, 3'd0, 0, 0, 1'b0);
        do_instr(OP_ST, 3'd2, 2, 1, 1'b0);
        do_instr(OP_JAL, 3'd0, 0, 0, 1'b0);
        do_instr(OP_JALR, 3'd0, 1, 0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            op = legal_ops[$urandom_range(0, 8)];
            do f3 = 3'($urandom_range(0, 7)); while (!is_legal(op, f3));
            do_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        do_reset("reset_count");
        for (int k = 0; k < 5; k++) do_instr(legal_ops[k], 3'd0, 0, 0, 1'b1);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        idle_check_instret("instret_five", 32'd5);
`else
        idle_check_instret("instret_off", 32'd0);
`endif

        do_instr(7'b0000000, 3'd0, 0, 0, 1'b0);
        do_reset("reset_from_trap0");
        do_instr(OP_BR, 3'd2, 1, 0, 1'b0);
        do_reset("reset_from_trap_br");
        do_instr(OP_ST, 3'd4, 0, 0, 1'b0);
        do_reset("reset_from_trap_st");
        do_instr(OP_LD, 3'd6, 0, 0, 1'b0);
        do_reset("reset_from_trap_ld");

        model_instr(OP_ST, 3'd2, 0, 5, 1'b0);
        run(5);
        q.delete();
        do_reset("reset_mid_mem");
        do_instr(OP_I, 3'd0, 0, 0, 1'b0);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
        do_reset("reset_wrap");
        dut.instret_q = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
        do_instr(OP_I, 3'd0, 0, 0, 1'b0);
        idle_check_instret("instret_wrap", 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
